// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the regfile_sb register file and its busy scoreboard.
// Optional build macro REGFILE_SB_BYPASS_EN is consumed by regfile_sb, not by this package.
package regfile_sb_pkg;

    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_DEPTH      = 1 << REGFILE_ADDR_WIDTH;

    typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REGFILE_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: a reservation sets a bit, a writeback clears it.
// A same-cycle set and clear on one register leaves it busy (younger producer wins).
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    localparam int DEPTH     = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [DEPTH-1:0]      busy_vec,
    output logic                  any_busy
);

    logic [DEPTH-1:0] busy_vec_r;
    logic             any_busy_r;
    logic [DEPTH-1:0] set_mask_s;
    logic [DEPTH-1:0] clr_mask_s;
    logic [DEPTH-1:0] busy_nxt_s;

    // One-hot set/clear masks; address 0 never participates.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (set_en && (set_addr != '0)) begin
            set_mask_s[set_addr] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        if (clr_en && (clr_addr != '0)) begin
            clr_mask_s[clr_addr] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
    end

    // Next busy state: clear first, then set, so a new reservation dominates.
    always_comb begin
        busy_nxt_s    = (busy_vec_r & ~clr_mask_s) | set_mask_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Busy vector and its OR-reduction, both registered from the same next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec_r <= '0;
            any_busy_r <= 1'b0;
        end else begin
            busy_vec_r <= busy_nxt_s;
            any_busy_r <= |busy_nxt_s;
        end
    end

    assign busy_vec = busy_vec_r;
    assign any_busy = any_busy_r;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with busy scoreboard; register 0 is hardwired to zero.
// Define REGFILE_SB_BYPASS_EN to enable same-cycle write-through to the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    parameter int DEBUG_REG  = 3
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  ReadBusy1,
    output logic                  ReadBusy2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] ReserveRegister,
    input  logic                  Reserve,
    output logic [DATA_WIDTH-1:0] DebugData,
    output logic                  AnyBusy
);

    localparam int                    DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DEBUG_REG);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]      busy_vec_s;
    logic                  any_busy_s;
    logic                  write_en_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s [2];
    logic [DATA_WIDTH-1:0] rd_data_s [2];
    logic [1:0]            rd_busy_s;

    assign write_en_s   = RegWrite && (WriteRegister != '0);
    assign rd_addr_s[0] = ReadRegister1;
    assign rd_addr_s[1] = ReadRegister2;

`ifdef REGFILE_SB_BYPASS_EN
    logic bypass_ok_s;
    // Write-through is suppressed while in reset so every read returns 0 there.
    assign bypass_ok_s = Reset_n && write_en_s;
`endif

    regfile_sb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .set_en   (Reserve),
        .set_addr (ReserveRegister),
        .clr_en   (RegWrite),
        .clr_addr (WriteRegister),
        .busy_vec (busy_vec_s),
        .any_busy (any_busy_s)
    );

    // Data array; entry 0 is only ever loaded by reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (write_en_s) begin
            mem_r[WriteRegister] <= WriteData;
        end
    end

    // Read muxes for both ports, with optional write-through from the write port.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = '0;
            rd_busy_s[p] = 1'b0;
            if (rd_addr_s[p] == '0) begin
                rd_data_s[p] = '0;
                rd_busy_s[p] = 1'b0;
            end
`ifdef REGFILE_SB_BYPASS_EN
            else if (bypass_ok_s && (WriteRegister == rd_addr_s[p])) begin
                rd_data_s[p] = WriteData;
                rd_busy_s[p] = 1'b0;
            end
`endif
            else begin
                rd_data_s[p] = mem_r[rd_addr_s[p]];
                rd_busy_s[p] = busy_vec_s[rd_addr_s[p]];
            end
        end
    end

    assign ReadData1 = rd_data_s[0];
    assign ReadData2 = rd_data_s[1];
    assign ReadBusy1 = rd_busy_s[0];
    assign ReadBusy2 = rd_busy_s[1];
    assign AnyBusy   = any_busy_s;
    assign DebugData = mem_r[DBG_IDX];

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int DBG   = 3;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [AW-1:0] ReadRegister1, ReadRegister2, WriteRegister, ReserveRegister;
    logic [DW-1:0] ReadData1, ReadData2, WriteData, DebugData;
    logic          ReadBusy1, ReadBusy2, RegWrite, Reserve, AnyBusy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_busy [DEPTH];

    regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEBUG_REG(DBG)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .ReadRegister1   (ReadRegister1),
        .ReadRegister2   (ReadRegister2),
        .ReadData1       (ReadData1),
        .ReadData2       (ReadData2),
        .ReadBusy1       (ReadBusy1),
        .ReadBusy2       (ReadBusy2),
        .WriteRegister   (WriteRegister),
        .WriteData       (WriteData),
        .RegWrite        (RegWrite),
        .ReserveRegister (ReserveRegister),
        .Reserve         (Reserve),
        .DebugData       (DebugData),
        .AnyBusy         (AnyBusy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
        if (RegWrite && WriteRegister == a) return WriteData;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (RegWrite && WriteRegister == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 0; i < DEPTH; i++) r = r | m_busy[i];
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".rd1"},   ReadData1, exp_data(ReadRegister1));
        check({tag, ".rd2"},   ReadData2, exp_data(ReadRegister2));
        check({tag, ".busy1"}, 32'(ReadBusy1), 32'(exp_busy(ReadRegister1)));
        check({tag, ".busy2"}, 32'(ReadBusy2), 32'(exp_busy(ReadRegister2)));
        check({tag, ".any"},   32'(AnyBusy), 32'(exp_any()));
        check({tag, ".dbg"},   DebugData, m_mem[DBG]);
    endtask

    // Drive one cycle at the falling edge, check before the rising edge, then advance the model.
    task automatic cycle(input string tag, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic rs, input logic [AW-1:0] ra,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge Clk);
        RegWrite = we; WriteRegister = wa; WriteData = wd;
        Reserve = rs; ReserveRegister = ra;
        ReadRegister1 = r1; ReadRegister2 = r2;
        #1;
        check_outputs(tag);
        @(posedge Clk);
        if (we && wa != 0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (rs && ra != 0) m_busy[ra] = 1'b1;
    endtask

    task automatic idle(input string tag, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        cycle(tag, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r1, r2);
    endtask

    initial begin
        RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        Reserve = 1'b0; ReserveRegister = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        Reset_n = 1'b1;
        model_clear();
        #2 Reset_n = 1'b0;
        #1;
        // Sweep all addresses on both ports while held in reset.
        for (int a = 0; a < DEPTH; a++) begin
            ReadRegister1 = AW'(a);
            ReadRegister2 = AW'(DEPTH - 1 - a);
            #1;
            check("rst.rd1", ReadData1, 32'h0);
            check("rst.rd2", ReadData2, 32'h0);
            check("rst.busy1", 32'(ReadBusy1), 32'h0);
            check("rst.busy2", 32'(ReadBusy2), 32'h0);
        end
        check("rst.any", 32'(AnyBusy), 32'h0);
        check("rst.dbg", DebugData, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Basic write/read and register 0.
        cycle("w7",    1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 5'd7);
        cycle("w0",    1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7);
        idle ("r0",    5'd0, 5'd7);
        // Reserve then write-back clears.
        cycle("res5",  1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0);
        cycle("wr5",   1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd5);
        idle ("r5",    5'd5, 5'd0);
        // Same-cycle reserve and write, same and different addresses.
        cycle("rw9",   1'b1, 5'd9, 32'h00000055, 1'b1, 5'd9, 5'd9, 5'd0);
        idle ("r9",    5'd9, 5'd9);
        cycle("rw46",  1'b1, 5'd6, 32'h00000066, 1'b1, 5'd4, 5'd4, 5'd6);
        idle ("r46",   5'd4, 5'd6);
        // Write to the debug register while reading it.
        cycle("byp3",  1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd0, 5'd3, 5'd3);
        cycle("byp3b", 1'b1, 5'd3, 32'h0BADF00D, 1'b1, 5'd3, 5'd3, 5'd9);
        idle ("r3",    5'd3, 5'd3);
        cycle("w3c",   1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 5'd3, 5'd0);
        // Reset in mid-operation.
        cycle("pre",   1'b1, 5'd8, 32'h00000077, 1'b1, 5'd2, 5'd2, 5'd8);
        idle ("pre2",  5'd2, 5'd8);
        @(negedge Clk);
        RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'h11111111;
        Reserve = 1'b0; ReadRegister1 = 5'd2; ReadRegister2 = 5'd8;
        Reset_n = 1'b0;
        #1;
        check("mrst.busy2", 32'(ReadBusy1), 32'h0);
        check("mrst.r8",    ReadData2, 32'h0);
        check("mrst.any",   32'(AnyBusy), 32'h0);
        check("mrst.dbg",   DebugData, 32'h0);
        model_clear();
        @(negedge Clk);
        RegWrite = 1'b0;
        Reset_n = 1'b1;
        idle("post", 5'd8, 5'd3);

        // Randomized traffic; narrow address range half of the time to force collisions.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa, ra, r1, r2;
            logic narrow;
            narrow = 1'($urandom_range(0, 1));
            wa = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ra = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r2 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            cycle("rnd", 1'($urandom_range(0, 1)), wa, DW'($urandom),
                  1'($urandom_range(0, 1)), ra, r1, r2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
